// File: rtl/irq_sequencer.sv
// Interrupt sequencer between the peripheral interrupt lines and CP0: it captures and presents the
// pending vector, arbitrates and acknowledges the taken source, flushes the pipeline and watches handler residency.
module irq_sequencer #(
    parameter logic [5:0] EDGE_MASK  = 6'b000011,
    parameter int         WDOG_LIMIT = 1024,
    parameter int         CNT_W      = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_irq_src,
    input  logic       i_cp0_req,
    input  logic       i_cp0_is_int,
    input  logic       i_eret,
    output logic [5:0] o_hw_int,
    output logic [5:0] o_irq_ack,
    output logic [2:0] o_irq_id,
    output logic       o_flush,
    output logic       o_in_handler,
    output logic       o_wdog_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TAKE    = 2'd1,
        S_HANDLER = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WDOG_LIMIT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [5:0]       r_irq_q;
    logic [5:0]       r_pend_edge;
    logic [5:0]       r_hw_int;
    logic             r_armed;
    logic [2:0]       r_sel;
    logic [2:0]       r_irq_id;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wdog;

    logic [5:0]       w_rise;
    logic [5:0]       w_clr;
    logic [5:0]       w_pending;
    logic [5:0]       w_pend_edge_next;
    logic [2:0]       w_sel;

    // A line already high when reset releases is not treated as an edge; r_armed gates the first cycle.
    assign w_rise           = r_armed ? (i_irq_src & ~r_irq_q & EDGE_MASK) : 6'd0;
    assign w_pending        = (r_pend_edge & EDGE_MASK) | (r_irq_q & ~EDGE_MASK);
    assign w_pend_edge_next = (r_pend_edge & ~w_clr) | w_rise;

    always_comb begin
        w_sel = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (r_hw_int[i]) begin
                w_sel = 3'(i);
            end
        end
    end

    // Only edge sources are cleared on take; level sources drop when the peripheral is serviced.
    always_comb begin
        w_clr = 6'd0;
        if (r_state == S_TAKE) begin
            w_clr[r_sel] = EDGE_MASK[r_sel];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cp0_req) begin
                    if (!i_cp0_is_int) begin
                        w_state_next = S_HANDLER;
                    end else if (r_hw_int != 6'd0) begin
                        w_state_next = S_TAKE;
                    end
                end
            end
            S_TAKE:    w_state_next = S_HANDLER;
            S_HANDLER: begin
                if (i_eret) begin
                    w_state_next = S_IDLE;
                end
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_irq_q     <= 6'd0;
            r_pend_edge <= 6'd0;
            r_hw_int    <= 6'd0;
            r_armed     <= 1'b0;
            r_sel       <= 3'd0;
            r_irq_id    <= 3'd7;
            r_cnt       <= '0;
            r_wdog      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_irq_q     <= i_irq_src;
            r_pend_edge <= w_pend_edge_next;
            // The source being acknowledged is withdrawn from CP0 immediately.
            r_hw_int    <= w_pending & ~w_clr;
            r_armed     <= 1'b1;
            if (r_state == S_IDLE && w_state_next == S_TAKE) begin
                r_sel    <= w_sel;
                r_irq_id <= w_sel;
            end else if (r_state == S_IDLE && w_state_next == S_HANDLER) begin
                r_irq_id <= 3'd7;
            end else if (r_state == S_HANDLER && i_eret) begin
                r_irq_id <= 3'd7;
            end
            if (r_state == S_HANDLER && !i_eret) begin
                if (r_cnt != LIMIT) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (r_cnt >= LIMIT_M1) begin
                    r_wdog <= 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_hw_int     = r_hw_int;
    assign o_irq_ack    = (r_state == S_TAKE) ? (6'd1 << r_sel) : 6'd0;
    assign o_irq_id     = r_irq_id;
    assign o_flush      = (r_state == S_TAKE);
    assign o_in_handler = (r_state != S_IDLE);
    assign o_wdog_err   = r_wdog;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios then random traffic, every cycle compared against
// an event-level reference model of pending sources, service and watchdog.
module tb_irq_sequencer;

    localparam logic [5:0] EDGE = 6'b000011;
    localparam int         LIM  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] irq_src;
    logic       cp0_req;
    logic       cp0_is_int;
    logic       eret;
    logic [5:0] hw_int;
    logic [5:0] irq_ack;
    logic [2:0] irq_id;
    logic       flush;
    logic       in_handler;
    logic       wdog_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_sequencer #(.EDGE_MASK(EDGE), .WDOG_LIMIT(LIM), .CNT_W(16)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_irq_src    (irq_src),
        .i_cp0_req    (cp0_req),
        .i_cp0_is_int (cp0_is_int),
        .i_eret       (eret),
        .o_hw_int     (hw_int),
        .o_irq_ack    (irq_ack),
        .o_irq_id     (irq_id),
        .o_flush      (flush),
        .o_in_handler (in_handler),
        .o_wdog_err   (wdog_err)
    );

    // Reference model: what CP0 sees, which source is being serviced, how long the handler has run.
    logic [5:0] m_prev;
    logic       m_armed;
    logic [5:0] m_latched;
    logic [5:0] m_hw;
    logic       m_taking;
    logic       m_busy;
    logic [2:0] m_sel;
    logic [2:0] m_id;
    int         m_cnt;
    logic       m_wdog;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [5:0] v);
        for (int i = 0; i < 6; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd7;
    endfunction

    task automatic model_step();
        logic [5:0] em;
        logic [5:0] rise;
        logic [5:0] served;
        logic [5:0] hw_n;
        em = EDGE;
        if (!reset) begin
            m_prev = 6'd0; m_armed = 1'b0; m_latched = 6'd0; m_hw = 6'd0;
            m_taking = 1'b0; m_busy = 1'b0; m_sel = 3'd0; m_id = 3'd7;
            m_cnt = 0; m_wdog = 1'b0;
            return;
        end
        rise   = m_armed ? (irq_src & ~m_prev & em) : 6'd0;
        served = (m_taking && em[m_sel]) ? (6'd1 << m_sel) : 6'd0;
        hw_n   = (m_latched | (m_prev & ~em)) & ~served;
        m_latched = (m_latched & ~served) | rise;
        if (m_taking) begin
            m_taking = 1'b0;
            m_busy   = 1'b1;
            m_cnt    = 0;
        end else if (m_busy) begin
            if (eret) begin
                m_busy = 1'b0;
                m_id   = 3'd7;
                m_cnt  = 0;
            end else begin
                if (m_cnt < LIM) m_cnt++;
                if (m_cnt == LIM) m_wdog = 1'b1;
            end
        end else if (cp0_req) begin
            if (!cp0_is_int) begin
                m_busy = 1'b1;
                m_id   = 3'd7;
            end else if (m_hw != 6'd0) begin
                m_taking = 1'b1;
                m_sel    = lowest(m_hw);
                m_id     = m_sel;
            end
        end
        m_hw    = hw_n;
        m_prev  = irq_src;
        m_armed = 1'b1;
    endtask

    task automatic check_outputs();
        check("hw_int", hw_int, m_hw);
        check("irq_ack", irq_ack, m_taking ? (6'd1 << m_sel) : 6'd0);
        check("irq_id", irq_id, m_id);
        check("flush", flush, m_taking);
        check("in_handler", in_handler, m_taking | m_busy);
        check("wdog_err", wdog_err, m_wdog);
    endtask

    task automatic tick();
        #3;
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic take_int();
        cp0_req = 1'b1; cp0_is_int = 1'b1;
        tick();
        cp0_req = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        reset = 1'b0; irq_src = 6'h3F; cp0_req = 1'b0; cp0_is_int = 1'b0; eret = 1'b0;
        @(posedge clk);
        model_step();
        #1;
        tick();
        check("rst_hw_int", hw_int, 6'h00);
        check("rst_irq_id", irq_id, 3'd7);
        check("rst_in_handler", in_handler, 1'b0);

        // Lines held high through reset release: only level bits appear.
        reset = 1'b1;
        tick();
        tick();
        check("release_hw_int", hw_int, 6'h3C);
        irq_src = 6'h00;
        repeat (3) tick();

        // Edge source 0 pulsed and taken.
        irq_src = 6'h01; tick();
        irq_src = 6'h00; tick();
        check("edge0_hw_int", hw_int, 6'h01);
        take_int();
        check("take0_ack", irq_ack, 6'h01);
        check("take0_flush", flush, 1'b1);
        check("take0_id", irq_id, 3'd0);
        tick();
        check("take0_hw_cleared", hw_int, 6'h00);
        repeat (3) tick();
        check("take0_in_handler", in_handler, 1'b1);
        do_eret();
        check("eret_in_handler", in_handler, 1'b0);
        check("eret_irq_id", irq_id, 3'd7);

        // Level source 2 held, edge source 1 pulsed: priority then level persistence.
        irq_src = 6'h06; tick();
        irq_src = 6'h04; tick();
        take_int();
        check("prio_id", irq_id, 3'd1);
        check("prio_ack", irq_ack, 6'h02);
        repeat (2) tick();
        do_eret();
        check("level_hw_int", hw_int, 6'h04);
        take_int();
        check("level_id", irq_id, 3'd2);
        tick();
        do_eret();
        irq_src = 6'h00;
        repeat (3) tick();

        // Re-pulse of source 0 while it is being taken: the new edge survives.
        irq_src = 6'h01; tick();
        irq_src = 6'h00; tick();
        take_int();
        irq_src = 6'h01; tick();
        irq_src = 6'h00; tick();
        do_eret();
        check("setwins_hw_int", hw_int, 6'h01);
        take_int();
        tick();
        do_eret();

        // Internal exception and watchdog.
        cp0_req = 1'b1; cp0_is_int = 1'b0; tick();
        cp0_req = 1'b0;
        check("exc_id", irq_id, 3'd7);
        check("exc_ack", irq_ack, 6'h00);
        check("exc_flush", flush, 1'b0);
        check("exc_in_handler", in_handler, 1'b1);
        repeat (LIM - 1) tick();
        check("wdog_before", wdog_err, 1'b0);
        tick();
        check("wdog_at_limit", wdog_err, 1'b1);
        repeat (2) tick();
        do_eret();
        check("wdog_sticky", wdog_err, 1'b1);

        // Reset in the middle of a handler.
        cp0_req = 1'b1; cp0_is_int = 1'b0; tick();
        cp0_req = 1'b0;
        repeat (2) tick();
        reset = 1'b0; tick();
        check("midrst_in_handler", in_handler, 1'b0);
        check("midrst_wdog", wdog_err, 1'b0);
        check("midrst_id", irq_id, 3'd7);
        reset = 1'b1;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            end
            cp0_req    = ($urandom_range(0, 3) == 0);
            cp0_is_int = ($urandom_range(0, 3) != 0);
            eret       = ($urandom_range(0, 5) == 0);
            reset      = ($urandom_range(0, 299) != 0);
            tick();
        end
        reset = 1'b1; cp0_req = 1'b0; eret = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Sits between the peripheral interrupt lines (timers, interrupt generator) and the CP0 external-interrupt input `Exter_HW_Int`.
- Synchronises and latches the six interrupt sources, then presents the pending vector to CP0.
- When CP0 takes an external interrupt, it:
  - arbitrates which source is being serviced,
  - acknowledges that source,
  - issues a one-cycle pipeline flush,
  - tracks handler residency until `eret` (`EXL_clr`).

Parameters:
- `EDGE_MASK`, `6'b000011`: bit i = 1 means source i is edge-triggered (latched pending); bit i = 0 means level-triggered.
- `WDOG_LIMIT`, 1024: handler-residency cycle count at which `wdog_err` sets.
- `CNT_W`, 16: width of the residency counter; must satisfy 2^`CNT_W` > `WDOG_LIMIT`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `irq_src`  in  6  raw peripheral interrupt lines, asynchronous to nothing (same clock domain).
- `cp0_req`  in  1  CP0 request (`CP0_req`), high in the cycle CP0 accepts an exception or interrupt.
- `cp0_is_int`  in  1  qualifies `cp0_req`: 1 means the accepted event is an external interrupt (ExcCode 0).
- `eret`  in  1  `EXL_clr` pulse from the M stage.
- `hw_int`  out  6  pending vector to CP0 `Exter_HW_Int`.
- `irq_ack`  out  6  one-hot, one-cycle acknowledge to the serviced source.
- `irq_id`  out  3  index of the serviced source; 3'd7 = none.
- `flush`  out  1  one-cycle pipeline flush on interrupt take.
- `in_handler`  out  1  high from take until `eret`.
- `wdog_err`  out  1  sticky: handler residency reached `WDOG_LIMIT`.

Behaviour:

Reset (`reset` == 0 at a posedge) clears:
- `pending`, `irq_q`, the counter and `wdog_err`;
- `hw_int` = 0, `irq_ack` = 0, `flush` = 0, `in_handler` = 0;
- `irq_id` = 7; state = IDLE.

Reset overrides everything, including mid-handler and same-cycle take.

Edge capture:
- `irq_q` registers `irq_src` every cycle.
- For an edge source, a rise (`irq_src` & ~`irq_q`) sets `pending[i]` on the next edge.
- For a level source, `pending[i]` = `irq_q[i]`; it is never latched.

Output:
- `hw_int` = `pending`, registered.
- Interrupt latency is 2 clocks: `irq_src` rise to `hw_int` high.

Priority:
- Lowest index wins. `sel` = lowest set bit of `hw_int` at the take cycle.

FSM states: IDLE, TAKE, HANDLER.

IDLE:
- On `cp0_req` & `cp0_is_int` & (`hw_int` != 0), go to TAKE.
- On `cp0_req` with `cp0_is_int` = 0 (internal exception), go to HANDLER with `irq_id` = 7 and no ack/flush.
- `cp0_req` & `cp0_is_int` with `hw_int` == 0 is a protocol error: ignore it and stay in IDLE.

TAKE (exactly 1 cycle):
- `irq_id` = `sel`, `irq_ack[sel]` = 1, `flush` = 1.
- Clears `pending[sel]` if `sel` is an edge source.
- Always goes to HANDLER.

HANDLER:
- `in_handler` = 1; the counter increments each cycle, saturating at `WDOG_LIMIT`.
- When the counter reaches `WDOG_LIMIT`, `wdog_err` sets and stays set until reset.
- On `eret`: go to IDLE, counter = 0, `irq_id` = 7, `in_handler` falls the next cycle.
- `eret` in IDLE or TAKE is ignored.

Simultaneous events:
- A new edge on `sel` in the same cycle as its TAKE clear leaves `pending[sel]` = 1 (set wins).
- `cp0_req` during HANDLER is ignored; CP0 gates requests with EXL.
- `eret` and `cp0_req` in the same HANDLER cycle: `eret` wins. The request is re-evaluated from IDLE on the following cycle.

Level sources:
- Never cleared by the sequencer.
- The peripheral must drop its line in response to `irq_ack` or a handler store.

Counter:
- Unsigned, `CNT_W` bits.
- Never wraps: it saturates at `WDOG_LIMIT`.

Test Plan:
- Reset low 2 cycles with `irq_src` = 6'h3F → all outputs 0, `irq_id` = 7. After release with the lines held high: `hw_int` = 6'h3C two cycles later; no edges are captured for bits 0–1.
- Pulse `irq_src[0]` one cycle, then `cp0_req` = `cp0_is_int` = 1:
  - `hw_int` = 6'h01 at +2;
  - TAKE cycle shows `irq_ack` = 6'h01, `flush` = 1, `irq_id` = 0;
  - `hw_int` returns to 0 the next cycle;
  - `in_handler` stays 1 until `eret`.
- Hold `irq_src[2]` (level) and pulse `irq_src[1]`, then take → `irq_id` = 1, `irq_ack` = 6'h02. After `eret`, `hw_int` = 6'h04 remains; a second take gives `irq_id` = 2.
- Take with `irq_src[0]` re-pulsing in the TAKE cycle → `pending[0]` stays 1 and `hw_int` = 6'h01 after `eret`.
- `cp0_req` with `cp0_is_int` = 0 → HANDLER with `irq_id` = 7, no ack, no flush. With `WDOG_LIMIT` = 8 and no `eret` for 10 cycles, `wdog_err` = 1 at cycle 8 and stays 1 after `eret`.
- Assert reset (low) during HANDLER → next cycle IDLE, `in_handler` = 0, counter = 0, `wdog_err` = 0.
